// File: rtl/pipe_pkg.sv
// Shared definitions for the generic inter-stage pipeline buffer:
// state encodings, default bundle/counter widths and the bubble fill value.
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  typedef enum logic [1:0] {
    S_EMPTY = ST_EMPTY,
    S_ONE   = ST_ONE,
    S_TWO   = ST_TWO
  } buf_state_e;

  // Default packed stage-bundle width and stall counter width.
  localparam int PIPE_WIDTH  = 32;
  localparam int STALL_CNT_W = 16;

  // Bubble is all-zero: every control enable in a packed bundle deasserted.
  localparam logic BUBBLE_BIT = 1'b0;

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Handshake/status bundle between a pipeline stage buffer and its neighbours.
// slave is the buffer's view; master is the surrounding stages' view.
interface pipe_stage_buf_if
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH,
  parameter int CNT_W = STALL_CNT_W
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cnt;

  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, occupancy, stall_cnt
  );

  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, occupancy, stall_cnt
  );
endinterface

// File: rtl/pipe_stage_buf.sv
// Two-entry skid pipeline register with flush and saturating stall counter.
// All state moves on the falling clock edge, like the older fixed-field buffers.
//
// state   | meaning
// S_EMPTY | nothing held, out_data = BUBBLE
// S_ONE   | main holds the head bundle
// S_TWO   | main holds head, skid holds the next bundle; upstream blocked
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int               WIDTH  = PIPE_WIDTH,
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{BUBBLE_BIT}},
  parameter int               CNT_W  = STALL_CNT_W
) (
  input logic              clk,
  input logic              rst,
  pipe_stage_buf_if.slave  bus
);

  buf_state_e       state_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic             push;
  logic             pop;
  logic             out_valid;
  logic             in_ready;

  // Ready and valid decode only the state register, so upstream never sees
  // a combinational path from any input.
  assign in_ready  = (state_q != S_TWO);
  assign out_valid = (state_q != S_EMPTY);

  assign push = bus.in_valid & in_ready;
  assign pop  = out_valid & bus.out_ready;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !bus.out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      main_q      <= BUBBLE;
      skid_q      <= BUBBLE;
      stall_cnt_q <= '0;
    end else begin
      // Stall counting looks at the pre-flush state and survives a flush.
      stall_cnt_q <= stall_cnt_d;
      if (bus.flush) begin
        state_q <= S_EMPTY;
        main_q  <= BUBBLE;
        skid_q  <= BUBBLE;
      end else begin
        case (state_q)
          S_EMPTY: begin
            if (push) begin
              state_q <= S_ONE;
              main_q  <= bus.in_data;
            end
          end
          S_ONE: begin
            if (push && pop) begin
              main_q <= bus.in_data;
            end else if (push) begin
              state_q <= S_TWO;
              skid_q  <= bus.in_data;
            end else if (pop) begin
              state_q <= S_EMPTY;
              main_q  <= BUBBLE;
            end
          end
          S_TWO: begin
            if (pop) begin
              state_q <= S_ONE;
              main_q  <= skid_q;
              skid_q  <= BUBBLE;
            end
          end
          default: begin
            state_q <= S_EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
          end
        endcase
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = main_q;
  assign bus.occupancy = state_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: reset, streaming, backpressure, flush,
// pop/push at one entry, mid-run reset and stall counter saturation.
module tb_pipe_stage_buf;

  localparam int W = 32;
  localparam int C = 4;

  logic clk = 1'b1;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  pipe_stage_buf_if #(.WIDTH(W), .CNT_W(C)) bus ();

  pipe_stage_buf #(.WIDTH(W), .BUBBLE('0), .CNT_W(C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic edge_step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    edge_step();
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    rst = 1'b1;
    #2;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); else n_pass++;
    n_total++; if (bus.out_data !== 32'h0) $display("FAIL reset_out_data got=%h exp=0", bus.out_data); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); else n_pass++;
    n_total++; if (bus.occupancy !== 2'd0) $display("FAIL reset_occ got=%0d exp=0", bus.occupancy); else n_pass++;
    n_total++; if (bus.stall_cnt !== 4'd0) $display("FAIL reset_stall got=%0d exp=0", bus.stall_cnt); else n_pass++;
    rst = 1'b0;
    edge_step();
  endtask

  task automatic test_streaming();
    logic [W-1:0] vals [3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = vals[i];
      edge_step();
      n_total++; if (bus.out_data !== vals[i]) $display("FAIL stream_data[%0d] got=%h exp=%h", i, bus.out_data, vals[i]); else n_pass++;
      n_total++; if (bus.occupancy !== 2'd1) $display("FAIL stream_occ[%0d] got=%0d exp=1", i, bus.occupancy); else n_pass++;
    end
    bus.in_valid = 1'b0;
    edge_step();
    n_total++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) $display("FAIL stream_drain got v=%0b d=%h exp v=0 d=0", bus.out_valid, bus.out_data); else n_pass++;
    n_total++; if (bus.stall_cnt !== 4'd0) $display("FAIL stream_stall got=%0d exp=0", bus.stall_cnt); else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hA;
    edge_step();
    n_total++; if (bus.occupancy !== 2'd1 || bus.out_data !== 32'hA) $display("FAIL bp_first got occ=%0d d=%h exp occ=1 d=a", bus.occupancy, bus.out_data); else n_pass++;
    bus.in_data = 32'hB;
    edge_step();
    n_total++; if (bus.occupancy !== 2'd2 || bus.in_ready !== 1'b0) $display("FAIL bp_full got occ=%0d rdy=%0b exp occ=2 rdy=0", bus.occupancy, bus.in_ready); else n_pass++;
    bus.in_data = 32'hC;
    edge_step();
    n_total++; if (bus.occupancy !== 2'd2 || bus.out_data !== 32'hA) $display("FAIL bp_hold got occ=%0d d=%h exp occ=2 d=a", bus.occupancy, bus.out_data); else n_pass++;
    n_total++; if (bus.stall_cnt !== 4'd2) $display("FAIL bp_stall got=%0d exp=2", bus.stall_cnt); else n_pass++;
    bus.out_ready = 1'b1;
    edge_step();
    n_total++; if (bus.out_data !== 32'hB || bus.occupancy !== 2'd1 || bus.in_ready !== 1'b1) $display("FAIL bp_pop1 got d=%h occ=%0d rdy=%0b exp d=b occ=1 rdy=1", bus.out_data, bus.occupancy, bus.in_ready); else n_pass++;
    edge_step();
    n_total++; if (bus.out_data !== 32'hC || bus.occupancy !== 2'd1) $display("FAIL bp_pop2 got d=%h occ=%0d exp d=c occ=1", bus.out_data, bus.occupancy); else n_pass++;
    bus.in_valid = 1'b0;
    edge_step();
    n_total++; if (bus.occupancy !== 2'd0 || bus.stall_cnt !== 4'd2) $display("FAIL bp_end got occ=%0d stall=%0d exp occ=0 stall=2", bus.occupancy, bus.stall_cnt); else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h5;
    edge_step();
    bus.in_data = 32'h6;
    edge_step();
    n_total++; if (bus.occupancy !== 2'd2) $display("FAIL flush_pre_occ got=%0d exp=2", bus.occupancy); else n_pass++;
    bus.in_data = 32'h7;
    bus.flush   = 1'b1;
    edge_step();
    n_total++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.occupancy !== 2'd0) $display("FAIL flush_empty got v=%0b d=%h occ=%0d exp v=0 d=0 occ=0", bus.out_valid, bus.out_data, bus.occupancy); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b1 || bus.stall_cnt !== 4'd2) $display("FAIL flush_rdy_stall got rdy=%0b stall=%0d exp rdy=1 stall=2", bus.in_ready, bus.stall_cnt); else n_pass++;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    edge_step();
    n_total++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) $display("FAIL flush_no7 got v=%0b d=%h exp v=0 d=0", bus.out_valid, bus.out_data); else n_pass++;
  endtask

  task automatic test_pop_push_one();
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h1;
    edge_step();
    n_total++; if (bus.out_data !== 32'h1) $display("FAIL pp_first got=%h exp=1", bus.out_data); else n_pass++;
    bus.in_data = 32'h2;
    edge_step();
    n_total++; if (bus.out_data !== 32'h2 || bus.occupancy !== 2'd1) $display("FAIL pp_swap got d=%h occ=%0d exp d=2 occ=1", bus.out_data, bus.occupancy); else n_pass++;
    bus.in_valid = 1'b0;
    edge_step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h44;
    edge_step();
    bus.in_data = 32'h55;
    edge_step();
    bus.in_valid = 1'b0;
    edge_step();
    n_total++; if (bus.occupancy !== 2'd2 || bus.stall_cnt === 4'd0) $display("FAIL rmid_pre got occ=%0d stall=%0d exp occ=2 stall>0", bus.occupancy, bus.stall_cnt); else n_pass++;
    rst = 1'b1;
    #1;
    n_total++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.in_ready !== 1'b1) $display("FAIL rmid_async got v=%0b d=%h rdy=%0b exp v=0 d=0 rdy=1", bus.out_valid, bus.out_data, bus.in_ready); else n_pass++;
    n_total++; if (bus.occupancy !== 2'd0 || bus.stall_cnt !== 4'd0) $display("FAIL rmid_cnt got occ=%0d stall=%0d exp occ=0 stall=0", bus.occupancy, bus.stall_cnt); else n_pass++;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h66;
    edge_step();
    n_total++; if (bus.out_data !== 32'h66 || bus.occupancy !== 2'd1) $display("FAIL rmid_first_push got d=%h occ=%0d exp d=66 occ=1", bus.out_data, bus.occupancy); else n_pass++;
    bus.in_valid = 1'b0;
    edge_step();
  endtask

  task automatic test_saturation();
    do_reset();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h99;
    edge_step();
    bus.in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      edge_step();
      if (k == 14) begin
        n_total++; if (bus.stall_cnt !== 4'd14) $display("FAIL sat_14 got=%0d exp=14", bus.stall_cnt); else n_pass++;
      end
      if (k == 15) begin
        n_total++; if (bus.stall_cnt !== 4'd15) $display("FAIL sat_15 got=%0d exp=15", bus.stall_cnt); else n_pass++;
      end
    end
    n_total++; if (bus.stall_cnt !== 4'd15) $display("FAIL sat_20 got=%0d exp=15", bus.stall_cnt); else n_pass++;
    edge_step();
    n_total++; if (bus.stall_cnt !== 4'd15 || bus.out_data !== 32'h99) $display("FAIL sat_hold got stall=%0d d=%h exp stall=15 d=99", bus.stall_cnt, bus.out_data); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_pop_push_one();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Generic parametrised pipeline-stage register; next generation of the fixed-field inter-stage buffers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one packed WIDTH-bit stage bundle with a valid/ready handshake, a 2-entry skid so upstream sees a registered ready, synchronous flush that inserts a bubble, and a saturating stall-cycle counter.
- Sits between any two pipeline stages; stage-specific fields are packed/unpacked by the instantiating top level.

Parameters:
- WIDTH, 32, bit width of the packed stage bundle.
- BUBBLE, {WIDTH{1'b0}}, value driven on out_data whenever no valid entry is held (all control enables deasserted).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  stage clock; all state updates on negedge clk, matching existing inter-stage buffers.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream presents a bundle.
- in_ready  out  1  buffer can accept; function of state register only (no combinational path from any input).
- in_data  in  WIDTH  upstream bundle.
- out_valid  out  1  out_data holds a valid bundle.
- out_ready  in  1  downstream accepts this edge (low = downstream stall).
- out_data  out  WIDTH  head bundle, or BUBBLE when empty.
- flush  in  1  discard all held entries at next negedge (branch taken / hazard squash).
- occupancy  out  2  entries held: 0, 1 or 2.
- stall_cnt  out  CNT_W  saturating count of edges with out_valid=1 and out_ready=0.

Behaviour:
- Reset (rst=1, async, immediate): state EMPTY; main and skid regs = BUBBLE; out_valid=0; out_data=BUBBLE; in_ready=1; occupancy=0; stall_cnt=0.
- Sampled at each negedge: push = in_valid & in_ready; pop = out_valid & out_ready.
- States: EMPTY (occ 0), ONE (occ 1, main valid), TWO (occ 2, main + skid valid).
- in_ready = (state != TWO). out_valid = (state != EMPTY). out_data = main reg; main = BUBBLE whenever state is EMPTY.
- EMPTY: push -> ONE, main <= in_data; else stay.
- ONE: push & pop -> ONE, main <= in_data. push & !pop -> TWO, skid <= in_data. !push & pop -> EMPTY, main <= BUBBLE. Neither -> hold.
- TWO: no push possible. pop -> ONE, main <= skid, skid <= BUBBLE. !pop -> hold.
- Latency: bundle pushed at edge N is on out_data after edge N if the buffer was empty, or after pops drain earlier entries. Sustained throughput is one bundle per edge while out_ready=1.
- Ordering: strict FIFO; no duplication or loss except by flush.
- flush=1 (highest priority after rst): next state EMPTY, main and skid <= BUBBLE. A simultaneous push is dropped and a simultaneous pop is still considered taken by downstream. in_ready=1 after the edge.
- stall_cnt: increments when out_valid & !out_ready at an edge (pre-flush state). Holds at 2^CNT_W-1. Cleared only by rst; flush does not clear it.
- rst asserted mid-operation: all entries lost immediately, no partial update. First push is accepted at the first negedge after rst deasserts.
- in_data is ignored when push=0; out_data is stable between edges.

Decomposition:
- Shared package pipe_pkg: state encoding constants (ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2) and the default bubble constant.
- Stage bundle pack/unpack widths live in the top-level package.
- No sub-module: the state register, two data registers and the counter fit in one module.

Test Plan:
- Reset: rst=1 mid-run with occupancy=2 -> out_valid=0, out_data=0, in_ready=1, occupancy=0, stall_cnt=0 without a clk edge.
- Streaming: out_ready=1, push 0x11,0x22,0x33 on consecutive edges -> out_data 0x11,0x22,0x33 on consecutive edges, occupancy stays 1, stall_cnt=0.
- Backpressure: out_ready=0, push 0xA,0xB,0xC -> occupancy 2 and in_ready=0 after 0xB, so 0xC is not accepted. Then out_ready=1 -> 0xA, 0xB out in order, and 0xC is accepted once in_ready=1. stall_cnt counts the edges where out_ready was low with data held.
- Flush: occupancy=2 (0x5,0x6), flush=1 with in_valid=1, in_data=0x7 -> next edge out_valid=0, out_data=BUBBLE, occupancy=0, and 0x7 is never emitted.
- Pop-push at ONE: main=0x1, push 0x2 and pop same edge -> out_data=0x2, occupancy=1.
- Saturation: CNT_W=4, hold out_valid=1/out_ready=0 for 20 edges -> stall_cnt=15 and holds at 15.
